// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t        : controller states (IDLE, BUSY, DONE)
//   LEGAL_W        : widths accepted for the DW and WW parameters
//   is_legal_width : elaboration-time check of a width against LEGAL_W
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NUM_LEGAL_W = 5;
  localparam int unsigned LEGAL_W [NUM_LEGAL_W] = '{2, 4, 8, 16, 32};

  function automatic bit is_legal_width(input int unsigned w);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < NUM_LEGAL_W; i++) begin
      if (LEGAL_W[i] == w) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration (purely combinational).
//   rem_in  : (WW+1)-bit partial remainder before this step
//   bit_in  : next dividend bit, shifted in at the LSB
//   divisor : WW-bit divisor
//   rem_out : (WW+1)-bit partial remainder after this step
//   q_bit   : quotient bit produced by this step
module div_step #(
  parameter int unsigned WW = 8
) (
  input  logic [WW:0]   rem_in,
  input  logic          bit_in,
  input  logic [WW-1:0] divisor,
  output logic [WW:0]   rem_out,
  output logic          q_bit
);

  logic [WW+1:0] shifted;
  logic [WW:0]   diff;

  // The remainder is always below the divisor, so after the shift it stays
  // below 2*divisor and the difference, when kept, fits in WW+1 bits.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {2'b00, divisor});
    diff    = shifted[WW:0] - {1'b0, divisor};
    rem_out = q_bit ? diff : shifted[WW:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (A dividend, B divisor)
//   out_valid / out_ready: result handshake (Q quotient, R remainder, dz)
// B=0 skips the iterations and returns Q=all ones, R=0, dz=1.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned WW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] A,
  input  logic [WW-1:0] B,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] Q,
  output logic [WW-1:0] R,
  output logic          dz
);

  localparam int unsigned CW = $clog2(DW + 1);

  if (!is_legal_width(DW) || !is_legal_width(WW)) begin : g_bad_width
    $error("seq_divider: illegal width DW=%0d WW=%0d", DW, WW);
  end

  state_t        state_q, state_d;
  logic [DW-1:0] a_q;       // dividend bits shift out at the top, quotient bits in at the bottom
  logic [WW-1:0] b_q;
  logic [WW:0]   rem_q, rem_next;
  logic [CW-1:0] cnt_q;
  logic          q_bit;
  logic          accept, step, last_step, b_zero;

  div_step #(.WW(WW)) u_step (
    .rem_in  (rem_q),
    .bit_in  (a_q[DW-1]),
    .divisor (b_q),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    step      = 1'b0;
    last_step = 1'b0;
    b_zero    = (B == '0);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = b_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt_q == CW'(DW - 1)) begin
          last_step = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      Q         <= '0;
      R         <= '0;
      dz        <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        rem_q <= '0;
        cnt_q <= '0;
        if (b_zero) begin
          Q  <= '1;
          R  <= '0;
          dz <= 1'b1;
        end
      end
      if (step) begin
        a_q   <= {a_q[DW-2:0], q_bit};
        rem_q <= rem_next;
        cnt_q <= cnt_q + CW'(1);
        if (last_step) begin
          Q  <= {a_q[DW-2:0], q_bit};
          R  <= rem_next[WW-1:0];
          dz <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed DW=WW=8 cases and a randomized DW=16/WW=4
// run, both checked by queue-based scoreboards fed from observed accepts.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv8, ordy8, ir8, ov8, dz8;
  logic [7:0]  a8, b8, q8, r8;
  logic        iv16, ordy16, ir16, ov16, dz16;
  logic [15:0] a16, q16;
  logic [3:0]  b16, r16;

  seq_divider #(.DW(8), .WW(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .out_valid(ov8), .out_ready(ordy8), .Q(q8), .R(r8), .dz(dz8)
  );

  seq_divider #(.DW(16), .WW(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
    .out_valid(ov16), .out_ready(ordy16), .Q(q16), .R(r16), .dz(dz16)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb8[$];
  exp_t sb16[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc16 = 0;
  int   done16 = 0;
  bit   pv8 = 1'b0;
  bit   pv16 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer division; latency counted from the accept cycle
  function automatic exp_t model(input longint unsigned a, input longint unsigned b,
                                 input int dw, input int acc);
    exp_t e;
    if (b == 0) begin
      e.q   = 32'((64'd1 << dw) - 64'd1);
      e.r   = 32'd0;
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      e.q   = 32'(a / b);
      e.r   = 32'(a % b);
      e.dz  = 1'b0;
      e.lat = dw + 1;
    end
    e.acc = acc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Scoreboard for the 8/8 instance
  always @(negedge clk) begin
    if (rst) begin
      sb8.delete();
      pv8 = 1'b0;
    end else begin
      if (iv8 && ir8) sb8.push_back(model(64'(a8), 64'(b8), 8, cyc));
      if (ov8) begin
        chk("in_ready_in_done8", 32'(ir8), 32'd0);
        if (sb8.size() == 0) fail_now("unexpected_result8");
        else begin
          if (!pv8) chk("latency8", 32'(cyc - sb8[0].acc), 32'(sb8[0].lat));
          chk("q8", 32'(q8), sb8[0].q);
          chk("r8", 32'(r8), sb8[0].r);
          chk("dz8", 32'(dz8), 32'(sb8[0].dz));
          if (ordy8) void'(sb8.pop_front());
        end
      end
      pv8 = ov8;
    end
  end

  // Scoreboard for the 16/4 instance
  always @(negedge clk) begin
    if (rst) begin
      sb16.delete();
      pv16 = 1'b0;
    end else begin
      if (iv16 && ir16) begin
        sb16.push_back(model(64'(a16), 64'(b16), 16, cyc));
        acc16++;
      end
      if (ov16) begin
        chk("in_ready_in_done16", 32'(ir16), 32'd0);
        if (sb16.size() == 0) fail_now("unexpected_result16");
        else begin
          if (!pv16) chk("latency16", 32'(cyc - sb16[0].acc), 32'(sb16[0].lat));
          chk("q16", 32'(q16), sb16[0].q);
          chk("r16", 32'(r16), sb16[0].r);
          chk("dz16", 32'(dz16), 32'(sb16[0].dz));
          if (ordy16) begin
            void'(sb16.pop_front());
            done16++;
          end
        end
      end
      pv16 = ov16;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!ir8 && n < 200) begin
      tick();
      n++;
    end
    if (!ir8) fail_now("timeout_in_ready8");
    iv8 = 1'b1;
    a8  = a;
    b8  = b;
    tick();
    iv8 = 1'b0;
    a8  = 8'($urandom);
    b8  = 8'($urandom);
  endtask

  task automatic wait_out8();
    int n = 0;
    while (!ov8 && n < 200) begin
      tick();
      n++;
    end
    if (!ov8) fail_now("timeout_out_valid8");
  endtask

  task automatic consume8();
    ordy8 = 1'b1;
    tick();
    ordy8 = 1'b0;
    chk("idle_after_consume_in_ready8", 32'(ir8), 32'd1);
    chk("idle_after_consume_out_valid8", 32'(ov8), 32'd0);
  endtask

  task automatic check_res8(input string name, input int q, input int r, input bit z);
    chk({name, "_Q"}, 32'(q8), 32'(q));
    chk({name, "_R"}, 32'(r8), 32'(r));
    chk({name, "_dz"}, 32'(dz8), 32'(z));
  endtask

  task automatic check_reset8(input string name);
    chk({name, "_in_ready"}, 32'(ir8), 32'd1);
    chk({name, "_out_valid"}, 32'(ov8), 32'd0);
    check_res8(name, 0, 0, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    iv8 = 1'b0; ordy8 = 1'b0; a8 = '0; b8 = '0;
    iv16 = 1'b0; ordy16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) tick();
    check_reset8("reset");
    chk("reset_in_ready16", 32'(ir16), 32'd1);
    rst = 1'b0;
    tick();

    // 200/7 with a long back-pressure hold
    send8(8'd200, 8'd7);
    wait_out8();
    check_res8("div_200_7", 28, 4, 1'b0);
    repeat (20) tick();
    check_res8("held_200_7", 28, 4, 1'b0);
    chk("held_in_ready8", 32'(ir8), 32'd0);
    consume8();

    send8(8'd5, 8'd0);
    wait_out8();
    check_res8("div_5_0", 255, 0, 1'b1);
    consume8();

    send8(8'd255, 8'd1);
    wait_out8();
    check_res8("div_255_1", 255, 0, 1'b0);
    consume8();

    send8(8'd3, 8'd10);
    wait_out8();
    check_res8("div_3_10", 0, 3, 1'b0);
    consume8();

    // Abort 200/7 in its 4th BUSY cycle
    send8(8'd200, 8'd7);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset8("abort");
    tick();

    send8(8'd100, 8'd9);
    wait_out8();
    check_res8("div_100_9", 11, 1, 1'b0);
    consume8();

    // Random 16/4 traffic with in_valid held high throughout
    iv16 = 1'b1;
    n = 0;
    while (done16 < 40 && n < 4000) begin
      a16    = 16'($urandom);
      b16    = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
      ordy16 = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("random_results_reached16", 32'(done16 >= 40), 32'd1);
    iv16   = 1'b0;
    ordy16 = 1'b1;
    n = 0;
    while (sb16.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    ordy16 = 1'b0;
    tick();
    chk("accepts_vs_results16", 32'(acc16), 32'(done16));
    chk("final_in_ready16", 32'(ir16), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
